// File: rtl/bist_signature_checker_pkg.sv
// Shared definitions for the BIST signature checker: default parameter
// values and the FSM state encoding.
package bist_signature_checker_pkg;

    // Default MISR geometry: x^8 + x^4 + x^3 + x^2 + 1, starting from zero
    localparam int         DEF_WIDTH      = 8;
    localparam logic [7:0] DEF_POLY       = 8'h1D;
    localparam logic [7:0] DEF_SEED       = 8'h00;
    localparam logic [7:0] DEF_GOLDEN     = 8'h00;

    // Default compacted-cycle counter geometry
    localparam int         DEF_CNT_W      = 8;
    localparam logic [7:0] DEF_EXP_CYCLES = 8'd0;

    // Checker FSM states (2-bit codes)
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/bist_signature_checker_misr_reg.sv
// Multiple-input signature register used to compact the CUT response.
// A load restarts compaction from the seed; load together with step folds
// the first response word into the seed in the same cycle.
import bist_signature_checker_pkg::*;

module misr_reg #(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_next;

    // Next MISR value: shift left, fold the MSB back through the taps, mix in data
    always_comb begin
        w_base = i_load ? i_seed : r_q;
        w_next = {w_base[WIDTH-2:0], 1'b0}
               ^ (w_base[WIDTH-1] ? POLY : '0)
               ^ i_din;
    end

    // Signature register; a step takes priority over a plain reload
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= SEED;
        end else if (i_step) begin
            r_q <= w_next;
        end else if (i_load) begin
            r_q <= i_seed;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/bist_signature_checker.sv
// BIST signature checker: compacts the CUT response while the pulse
// controller runs, then compares signature and cycle count against golden
// values and holds a sticky pass/fail verdict until a new run or reset.
import bist_signature_checker_pkg::*;

module bist_signature_checker #(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(DEF_SEED),
    parameter logic [WIDTH-1:0] GOLDEN     = WIDTH'(DEF_GOLDEN),
    parameter int               CNT_W      = DEF_CNT_W,
    parameter logic [CNT_W-1:0] EXP_CYCLES = CNT_W'(DEF_EXP_CYCLES)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_running,
    input  logic             i_bist_end,
    input  logic [WIDTH-1:0] i_cut_resp,
    output logic [WIDTH-1:0] o_signature,
    output logic [CNT_W-1:0] o_cycles,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_fail
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cycles;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;

    logic             w_start;
    logic             w_misrLoad;
    logic             w_misrStep;
    logic             w_cntMax;
    logic             w_match;
    logic [WIDTH-1:0] w_signature;

    // Decode MISR control: a fresh run reloads the seed and compacts its first
    // word at once; inside COMPACT an active bist_end suppresses compaction
    always_comb begin
        w_start    = i_running && !i_bist_end;
        w_misrLoad = 1'b0;
        w_misrStep = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_misrLoad = w_start;
                w_misrStep = w_start;
            end
            ST_COMPACT: begin
                w_misrStep = w_start;
            end
            default: begin
                w_misrLoad = 1'b0;
                w_misrStep = 1'b0;
            end
        endcase
    end

    // Verdict inputs: counter saturation flag and golden comparison
    always_comb begin
        w_cntMax = (r_cycles == {CNT_W{1'b1}});
        w_match  = (w_signature == GOLDEN) && (r_cycles == EXP_CYCLES);
    end

    misr_reg #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_misrLoad),
        .i_step  (w_misrStep),
        .i_seed  (SEED),
        .i_din   (i_cut_resp),
        .o_q     (w_signature)
    );

    // Control FSM with saturating cycle counter and registered verdict
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cycles <= '0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_running && i_bist_end) begin
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (i_running) begin
                        r_cycles <= CNT_W'(1);
                        r_state  <= ST_COMPACT;
                    end
                end
                ST_COMPACT: begin
                    if (i_bist_end) begin
                        r_state <= ST_CHECK;
                    end else if (i_running) begin
                        if (!w_cntMax) begin
                            r_cycles <= r_cycles + CNT_W'(1);
                        end
                    end else begin
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_CHECK: begin
                    r_done  <= 1'b1;
                    r_pass  <= w_match;
                    r_fail  <= !w_match;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (w_start) begin
                        r_cycles <= CNT_W'(1);
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_fail   <= 1'b0;
                        r_state  <= ST_COMPACT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_signature = w_signature;
    assign o_cycles    = r_cycles;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_fail      = r_fail;

endmodule
